// File: rtl/diff_arbiter_seq.sv
// Two-requester round-robin arbiter that computes the index of the lowest
// differing bit of the granted operand pair, scanning one nibble per cycle.
module diff_arbiter_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] opa0,
    input  logic [WIDTH-1:0] opb0,
    input  logic [WIDTH-1:0] opa1,
    input  logic [WIDTH-1:0] opb1,
    input  logic             abort,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             done,
    output logic             rsp_id,
    output logic [5:0]       result,
    output logic             equal
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(WIDTH - 4);
    localparam logic [5:0] EQ_RES   = 6'(WIDTH);

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [5:0]       idx_q, idx_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             done_q, done_d;
    logic             rsp_id_q, rsp_id_d;
    logic [5:0]       result_q, result_d;
    logic             equal_q, equal_d;

    logic [3:0]       nib;
    logic [1:0]       nib_pos;
    logic             win;

    assign nib = x_q[3:0];

    always_comb begin
        nib_pos = 2'd0;
        casez (nib)
            4'b???1: nib_pos = 2'd0;
            4'b??10: nib_pos = 2'd1;
            4'b?100: nib_pos = 2'd2;
            4'b1000: nib_pos = 2'd3;
            default: nib_pos = 2'd0;
        endcase
    end

    // On a tie the requester not served last wins; otherwise the sole requester.
    always_comb begin
        win = 1'b0;
        if (req0 && req1) begin
            win = ~last_q;
        end else begin
            win = req1;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        x_d      = x_q;
        idx_d    = idx_q;
        gnt_d    = '0;
        done_d   = 1'b0;
        rsp_id_d = rsp_id_q;
        result_d = result_q;
        equal_d  = equal_q;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    x_d        = win ? (opa1 ^ opb1) : (opa0 ^ opb0);
                    idx_d      = '0;
                    gnt_d[win] = 1'b1;
                    rsp_id_d   = win;
                    last_d     = win;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (nib != 4'd0) begin
                    result_d = idx_q + {4'd0, nib_pos};
                    equal_d  = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else if (idx_q == LAST_IDX) begin
                    result_d = EQ_RES;
                    equal_d  = 1'b1;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    x_d   = x_q >> 4;
                    idx_d = idx_q + 6'd4;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            x_q      <= '0;
            idx_q    <= '0;
            gnt_q    <= '0;
            done_q   <= 1'b0;
            rsp_id_q <= 1'b0;
            result_q <= '0;
            equal_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            x_q      <= x_d;
            idx_q    <= idx_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            rsp_id_q <= rsp_id_d;
            result_q <= result_d;
            equal_q  <= equal_d;
        end
    end

    assign gnt    = gnt_q;
    assign busy   = (state_q == SCAN);
    assign done   = done_q;
    assign rsp_id = rsp_id_q;
    assign result = result_q;
    assign equal  = equal_q;

endmodule
